// File: rtl/tcm_port_arbiter_pkg.sv
// Shared types and widths for the TCM store-buffer port arbiter.
package tcm_arb_pkg;

  localparam int ADDR_WIDTH       = 32;
  localparam int SIZE_WIDTH       = 3;
  localparam int REG_DATA_WIDTH   = 32;
  localparam int BUS_DATA_WIDTH   = 32;
  localparam int STARVE_CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    OWNER_LSU,
    OWNER_DBG,
    OWNER_STBUF
  } tcm_arb_owner_t;

endpackage

// File: rtl/tcm_port_arbiter_if.sv
// Requester-side and TCM-side signals of the store-buffer port arbiter.
interface tcm_port_arbiter_if;
  import tcm_arb_pkg::*;

  logic                      lsu_rd_valid;
  logic                      lsu_rd_ready;
  logic [ADDR_WIDTH-1:0]     lsu_rd_addr;
  logic [SIZE_WIDTH-1:0]     lsu_rd_size;
  logic                      lsu_rsp_valid;

  logic                      stbuf_wr_valid;
  logic                      stbuf_wr_ready;
  logic [ADDR_WIDTH-1:0]     stbuf_wr_addr;
  logic [SIZE_WIDTH-1:0]     stbuf_wr_size;
  logic [REG_DATA_WIDTH-1:0] stbuf_wr_data;

  logic                      dbg_valid;
  logic                      dbg_ready;
  logic                      dbg_we;
  logic [ADDR_WIDTH-1:0]     dbg_addr;
  logic [SIZE_WIDTH-1:0]     dbg_size;
  logic [REG_DATA_WIDTH-1:0] dbg_wdata;
  logic                      dbg_rsp_valid;

  logic [BUS_DATA_WIDTH-1:0] rsp_data;

  logic [ADDR_WIDTH-1:0]     bus_tcm_stbuf_read_addr;
  logic [SIZE_WIDTH-1:0]     bus_tcm_stbuf_read_size;
  logic                      bus_tcm_stbuf_rd;
  logic [ADDR_WIDTH-1:0]     bus_tcm_stbuf_write_addr;
  logic [SIZE_WIDTH-1:0]     bus_tcm_stbuf_write_size;
  logic [REG_DATA_WIDTH-1:0] bus_tcm_stbuf_data;
  logic                      bus_tcm_stbuf_wr;
  logic [BUS_DATA_WIDTH-1:0] tcm_bus_stbuf_data;

  modport master (
    output lsu_rd_valid, lsu_rd_addr, lsu_rd_size,
    output stbuf_wr_valid, stbuf_wr_addr, stbuf_wr_size, stbuf_wr_data,
    output dbg_valid, dbg_we, dbg_addr, dbg_size, dbg_wdata,
    output tcm_bus_stbuf_data,
    input  lsu_rd_ready, lsu_rsp_valid, stbuf_wr_ready, dbg_ready, dbg_rsp_valid,
    input  rsp_data,
    input  bus_tcm_stbuf_read_addr, bus_tcm_stbuf_read_size, bus_tcm_stbuf_rd,
    input  bus_tcm_stbuf_write_addr, bus_tcm_stbuf_write_size, bus_tcm_stbuf_data,
    input  bus_tcm_stbuf_wr
  );

  modport slave (
    input  lsu_rd_valid, lsu_rd_addr, lsu_rd_size,
    input  stbuf_wr_valid, stbuf_wr_addr, stbuf_wr_size, stbuf_wr_data,
    input  dbg_valid, dbg_we, dbg_addr, dbg_size, dbg_wdata,
    input  tcm_bus_stbuf_data,
    output lsu_rd_ready, lsu_rsp_valid, stbuf_wr_ready, dbg_ready, dbg_rsp_valid,
    output rsp_data,
    output bus_tcm_stbuf_read_addr, bus_tcm_stbuf_read_size, bus_tcm_stbuf_rd,
    output bus_tcm_stbuf_write_addr, bus_tcm_stbuf_write_size, bus_tcm_stbuf_data,
    output bus_tcm_stbuf_wr
  );

endinterface

// File: rtl/tcm_port_arbiter_prio_starve.sv
// Two-requester fixed-priority arbiter; the low-priority side is forced to
// win once after waiting STARVE_LIMIT consecutive cycles.
module tcm_arb_prio_starve
  import tcm_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_hi,
  input  logic req_lo,
  output logic gnt_hi,
  output logic gnt_lo
);

  localparam logic [STARVE_CNT_WIDTH-1:0] LIMIT = STARVE_CNT_WIDTH'(STARVE_LIMIT);

  logic [STARVE_CNT_WIDTH-1:0] cnt_q;
  logic [STARVE_CNT_WIDTH-1:0] cnt_d;
  logic                        win_lo;

  assign win_lo = req_lo && (!req_hi || (cnt_q == LIMIT));

  // Grants are held low while reset is asserted so nothing is accepted.
  assign gnt_lo = rst && win_lo;
  assign gnt_hi = rst && req_hi && !win_lo;

  always_comb begin
    cnt_d = '0;
    if (req_lo && !win_lo) begin
      cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tcm_port_arbiter.sv
// Arbitrates the TCM store-buffer read and write channels between LSU,
// store buffer and debug port, and routes read data back to its owner.
module tcm_port_arbiter
  import tcm_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst,
  tcm_port_arbiter_if.slave bus
);

  logic           dbg_rd_req;
  logic           dbg_wr_req;
  logic           rd_gnt_lsu;
  logic           rd_gnt_dbg;
  logic           wr_gnt_stbuf;
  logic           wr_gnt_dbg;
  logic           rsp_pending_q;
  logic           rsp_pending_d;
  tcm_arb_owner_t rsp_owner_q;
  tcm_arb_owner_t rsp_owner_d;

  assign dbg_rd_req = bus.dbg_valid && !bus.dbg_we;
  assign dbg_wr_req = bus.dbg_valid &&  bus.dbg_we;

  tcm_arb_prio_starve #(.STARVE_LIMIT(STARVE_LIMIT)) u_rd_arb (
    .clk    (clk),
    .rst    (rst),
    .req_hi (bus.lsu_rd_valid),
    .req_lo (dbg_rd_req),
    .gnt_hi (rd_gnt_lsu),
    .gnt_lo (rd_gnt_dbg)
  );

  tcm_arb_prio_starve #(.STARVE_LIMIT(STARVE_LIMIT)) u_wr_arb (
    .clk    (clk),
    .rst    (rst),
    .req_hi (bus.stbuf_wr_valid),
    .req_lo (dbg_wr_req),
    .gnt_hi (wr_gnt_stbuf),
    .gnt_lo (wr_gnt_dbg)
  );

  assign bus.lsu_rd_ready     = rd_gnt_lsu;
  assign bus.stbuf_wr_ready   = wr_gnt_stbuf;
  assign bus.dbg_ready        = rd_gnt_dbg || wr_gnt_dbg;
  assign bus.bus_tcm_stbuf_rd = rd_gnt_lsu || rd_gnt_dbg;
  assign bus.bus_tcm_stbuf_wr = wr_gnt_stbuf || wr_gnt_dbg;

  // Ungranted channels drive zero address/size/data toward the TCM.
  always_comb begin
    bus.bus_tcm_stbuf_read_addr = '0;
    bus.bus_tcm_stbuf_read_size = '0;
    if (rd_gnt_lsu) begin
      bus.bus_tcm_stbuf_read_addr = bus.lsu_rd_addr;
      bus.bus_tcm_stbuf_read_size = bus.lsu_rd_size;
    end else if (rd_gnt_dbg) begin
      bus.bus_tcm_stbuf_read_addr = bus.dbg_addr;
      bus.bus_tcm_stbuf_read_size = bus.dbg_size;
    end
  end

  always_comb begin
    bus.bus_tcm_stbuf_write_addr = '0;
    bus.bus_tcm_stbuf_write_size = '0;
    bus.bus_tcm_stbuf_data       = '0;
    if (wr_gnt_stbuf) begin
      bus.bus_tcm_stbuf_write_addr = bus.stbuf_wr_addr;
      bus.bus_tcm_stbuf_write_size = bus.stbuf_wr_size;
      bus.bus_tcm_stbuf_data       = bus.stbuf_wr_data;
    end else if (wr_gnt_dbg) begin
      bus.bus_tcm_stbuf_write_addr = bus.dbg_addr;
      bus.bus_tcm_stbuf_write_size = bus.dbg_size;
      bus.bus_tcm_stbuf_data       = bus.dbg_wdata;
    end
  end

  // The owner tag only moves on a read grant; pending marks next-cycle data.
  always_comb begin
    rsp_pending_d = rd_gnt_lsu || rd_gnt_dbg;
    rsp_owner_d   = rsp_owner_q;
    if (rd_gnt_dbg) begin
      rsp_owner_d = OWNER_DBG;
    end else if (rd_gnt_lsu) begin
      rsp_owner_d = OWNER_LSU;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_pending_q <= 1'b0;
      rsp_owner_q   <= OWNER_LSU;
    end else begin
      rsp_pending_q <= rsp_pending_d;
      rsp_owner_q   <= rsp_owner_d;
    end
  end

  assign bus.lsu_rsp_valid = rsp_pending_q && (rsp_owner_q == OWNER_LSU);
  assign bus.dbg_rsp_valid = rsp_pending_q && (rsp_owner_q == OWNER_DBG);
  assign bus.rsp_data      = bus.tcm_bus_stbuf_data;

endmodule

// File: doc/tcm_port_arbiter.md
Name: tcm_port_arbiter

Overview:
- Shares the TCM store-buffer data port (separate read and write channels) between three requesters:
  - LSU load unit: reads only.
  - Store buffer: writes only.
  - Debug/loader port: reads or writes.
- Each channel is arbitrated independently with fixed priority plus starvation relief.
- Read responses (TCM data valid one cycle after rd) are routed back to the granted owner.
- Sits between the LSU/store-buffer/debug bus masters and the tcm block's bus_tcm_stbuf_* / tcm_bus_stbuf_data interface.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles the debug port may wait on a channel before it is forced to win once; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- lsu_rd_valid  in  1  LSU read request
- lsu_rd_ready  out  1  LSU request accepted this cycle
- lsu_rd_addr  in  `ADDR_WIDTH  byte address
- lsu_rd_size  in  `SIZE_WIDTH  bytes (1/2/4)
- lsu_rsp_valid  out  1  LSU read data valid
- stbuf_wr_valid  in  1  store-buffer write request
- stbuf_wr_ready  out  1  accepted
- stbuf_wr_addr  in  `ADDR_WIDTH  byte address
- stbuf_wr_size  in  `SIZE_WIDTH  bytes
- stbuf_wr_data  in  `REG_DATA_WIDTH  write data
- dbg_valid  in  1  debug request
- dbg_ready  out  1  accepted
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  `ADDR_WIDTH  byte address
- dbg_size  in  `SIZE_WIDTH  bytes
- dbg_wdata  in  `REG_DATA_WIDTH  write data
- dbg_rsp_valid  out  1  debug read data valid
- rsp_data  out  `BUS_DATA_WIDTH  read data, shared by both responders
- bus_tcm_stbuf_read_addr  out  `ADDR_WIDTH  to TCM
- bus_tcm_stbuf_read_size  out  `SIZE_WIDTH  to TCM
- bus_tcm_stbuf_rd  out  1  to TCM
- bus_tcm_stbuf_write_addr  out  `ADDR_WIDTH  to TCM
- bus_tcm_stbuf_write_size  out  `SIZE_WIDTH  to TCM
- bus_tcm_stbuf_data  out  `REG_DATA_WIDTH  to TCM
- bus_tcm_stbuf_wr  out  1  to TCM
- tcm_bus_stbuf_data  in  `BUS_DATA_WIDTH  from TCM

Behaviour:
- Handshake: transfer occurs when valid && ready in the same cycle. ready is combinational from the valids and arbiter state; no request is held internally.
- Read channel (LSU vs debug read, dbg_valid && !dbg_we):
  - LSU has priority.
  - Debug wins if LSU is idle, or if rd_starve_cnt == STARVE_LIMIT.
- Write channel (store buffer vs debug write, dbg_valid && dbg_we): same rule, using wr_starve_cnt.
- Starve counters:
  - Increment when debug requests that channel and loses; saturate at STARVE_LIMIT.
  - Clear to 0 when debug is granted on that channel, or does not request it.
- Debug issues only one request per cycle, on one channel. The other channel is free for its primary requester in the same cycle.
- TCM drive:
  - bus_tcm_stbuf_rd = read grant; bus_tcm_stbuf_wr = write grant.
  - Address/size/data come from the granted requester.
  - When not granted, address/size/data are 0.
- Read and write issued in the same cycle to overlapping bytes: permitted. TCM is write-first, so the read returns the new data; no arbiter action.
- Response:
  - rsp_owner register (tcm_arb_owner_t) and rsp_pending flag are captured at read grant.
  - Next cycle: rsp_pending = 1 asserts exactly one of lsu_rsp_valid / dbg_rsp_valid for one cycle.
  - rsp_data = tcm_bus_stbuf_data, passed through unregistered.
  - No response backpressure; consumers must take data in the valid cycle.
- Throughput: one read and one write per cycle. Back-to-back reads give back-to-back responses, latency exactly 1.
- Size: forwarded unmodified. Illegal sizes (0, 3, >4) are still granted; the TCM suppresses write enables; the read response is still generated.
- Reset (rst low, asynchronous):
  - Cleared: rsp_pending, rsp_owner=OWNER_LSU, both starve counters.
  - Outputs: all *_ready=0, all *_rsp_valid=0, bus_tcm_stbuf_rd/wr=0.
  - A pending response is dropped and never signalled.
  - Deassertion is synchronous to clk via an external synchronizer.

Decomposition:
- Package tcm_arb_pkg:
  - typedef enum logic[1:0] tcm_arb_owner_t {OWNER_LSU, OWNER_DBG, OWNER_STBUF}.
  - localparam STARVE_CNT_WIDTH = 4.
- Sub-module tcm_arb_prio_starve: a 2-requester priority arbiter with saturating starvation counter (inputs req_hi, req_lo; outputs gnt_hi, gnt_lo). Instantiated once per channel.
- Top level holds muxing and the response tag.

Test Plan:
- LSU read addr 0x100 size 4, others idle → cycle 0: lsu_rd_ready=1, rd=1, read_addr=0x100; cycle 1: lsu_rsp_valid=1, rsp_data equals TCM data.
- stbuf write 0x200 data 0xDEADBEEF and debug read 0x300 in the same cycle → both granted; wr=1 with data 0xDEADBEEF; dbg_rsp_valid next cycle.
- LSU reads every cycle, debug read pending, STARVE_LIMIT=4 → debug is granted in the 5th cycle; LSU ready=0 that cycle; counter returns to 0.
- Store buffer writes continuously, debug write 0x40 = 0x12345678 → debug granted after 4 losses; TCM write sees addr 0x40, data 0x12345678.
- LSU read granted, rst asserted before the next edge → no lsu_rsp_valid ever; all outputs 0 while reset is held.
- Debug read 0x10 granted, then LSU read 0x20 next cycle → dbg_rsp_valid at cycle 1, lsu_rsp_valid at cycle 2, never both in one cycle.
